// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: captures floor calls, picks the next target with LOOK
// scheduling, and times the door dwell at each served floor.
//   state  | meaning
//   S_IDLE | parked; target follows current floor; picks the next request
//   S_MOVE | issuing target_floor; retargets to a nearer stop ahead
//   S_DOOR | door held open for DOOR_DWELL cycles at the current floor
module elevator_request_scheduler #(
  parameter int NUM_FLOORS = 10,
  parameter int DOOR_DWELL = 10000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_call_valid,
  input  logic [3:0]            i_call_floor,
  input  logic [3:0]            i_current_floor,
  input  logic                  i_car_idle,
  output logic [3:0]            o_target_floor,
  output logic                  o_target_valid,
  output logic                  o_door_open,
  output logic                  o_dir_up,
  output logic [NUM_FLOORS-1:0] o_pending
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVE = 2'd1, S_DOOR = 2'd2} state_t;

  localparam logic [4:0]  FLOOR_LIMIT = 5'(NUM_FLOORS);
  localparam logic [31:0] DWELL_LAST  = 32'(DOOR_DWELL - 1);

  state_t                r_state;
  logic [3:0]            r_target_floor;
  logic                  r_target_valid;
  logic                  r_door_open;
  logic                  r_dir_up;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [31:0]           r_dwell_cnt;

  logic                  w_up_found, w_dn_found, w_sel_found, w_pend_at_cf;
  logic [3:0]            w_up_floor, w_dn_floor, w_sel_floor, w_alt_floor;
  logic                  w_nearer, w_arrive, w_call_ok, w_clr_en;
  logic [NUM_FLOORS-1:0] w_set, w_clr;

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    w_up_found   = 1'b0;
    w_up_floor   = '0;
    w_dn_found   = 1'b0;
    w_dn_floor   = '0;
    w_pend_at_cf = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (r_pending[i] && (4'(i) > i_current_floor)) begin
        w_up_found = 1'b1;
        w_up_floor = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (r_pending[i] && (4'(i) < i_current_floor)) begin
        w_dn_found = 1'b1;
        w_dn_floor = 4'(i);
      end
      if (r_pending[i] && (4'(i) == i_current_floor)) w_pend_at_cf = 1'b1;
    end
  end

  assign w_sel_found = r_dir_up ? w_up_found : w_dn_found;
  assign w_sel_floor = r_dir_up ? w_up_floor : w_dn_floor;
  assign w_alt_floor = r_dir_up ? w_dn_floor : w_up_floor;
  assign w_nearer    = w_sel_found &&
                       (r_dir_up ? (w_sel_floor < r_target_floor) : (w_sel_floor > r_target_floor));
  assign w_arrive    = (r_state == S_MOVE) && (i_current_floor == r_target_floor) && i_car_idle;
  assign w_call_ok   = i_call_valid && ({1'b0, i_call_floor} < FLOOR_LIMIT) &&
                       !((r_state == S_DOOR) && (i_call_floor == i_current_floor));
  assign w_clr_en    = ((r_state == S_IDLE) && w_pend_at_cf) || w_arrive;

  // On arrival target == current floor, so both clear sources name the current floor.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (w_call_ok && (4'(i) == i_call_floor)) w_set[i] = 1'b1;
      if (w_clr_en && (4'(i) == i_current_floor)) w_clr[i] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_pending      <= '0;
      r_target_floor <= '0;
      r_target_valid <= 1'b0;
      r_door_open    <= 1'b0;
      r_dir_up       <= 1'b1;
      r_dwell_cnt    <= '0;
    end else begin
      r_pending <= (r_pending | w_set) & ~w_clr;
      case (r_state)
        S_IDLE: begin
          r_target_floor <= i_current_floor;
          if (w_pend_at_cf) begin
            r_dwell_cnt <= '0;
            r_door_open <= 1'b1;
            r_state     <= S_DOOR;
          end else if (w_up_found || w_dn_found) begin
            r_target_valid <= 1'b1;
            r_state        <= S_MOVE;
            if (w_sel_found) begin
              r_target_floor <= w_sel_floor;
            end else begin
              r_dir_up       <= ~r_dir_up;
              r_target_floor <= w_alt_floor;
            end
          end
        end
        S_MOVE: begin
          if (w_arrive) begin
            r_target_valid <= 1'b0;
            r_door_open    <= 1'b1;
            r_dwell_cnt    <= '0;
            r_state        <= S_DOOR;
          end else if (w_nearer) begin
            r_target_floor <= w_sel_floor;
          end
        end
        S_DOOR: begin
          r_target_floor <= i_current_floor;
          if (r_dwell_cnt == DWELL_LAST) begin
            r_door_open <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_dwell_cnt <= r_dwell_cnt + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_target_floor = r_target_floor;
  assign o_target_valid = r_target_valid;
  assign o_door_open    = r_door_open;
  assign o_dir_up       = r_dir_up;
  assign o_pending      = r_pending;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: directed scenarios plus a randomized closed-loop
// run compared against a floor-list reference model.
module tb_elevator_request_scheduler;

  localparam int NF = 10;
  localparam int DW = 4;

  logic          clk, rst, call_valid, car_idle;
  logic [3:0]    call_floor, current_floor, target_floor;
  logic          target_valid, door_open, dir_up;
  logic [NF-1:0] pending;

  int n_checks, n_pass;

  // reference model: 0 = parked, 1 = travelling, 2 = door open
  int        m_state, m_tgt, m_cnt;
  bit        m_tv, m_door, m_up;
  bit [15:0] m_pend;

  elevator_request_scheduler #(.NUM_FLOORS(NF), .DOOR_DWELL(DW)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_call_valid    (call_valid),
    .i_call_floor    (call_floor),
    .i_current_floor (current_floor),
    .i_car_idle      (car_idle),
    .o_target_floor  (target_floor),
    .o_target_valid  (target_valid),
    .o_door_open     (door_open),
    .o_dir_up        (dir_up),
    .o_pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_sel(input bit up, input int cf, input bit [15:0] p);
    int best;
    best = -1;
    for (int f = 0; f < NF; f++) begin
      if (p[f]) begin
        if (up && f > cf && (best < 0 || f < best)) best = f;
        if (!up && f < cf && (best < 0 || f > best)) best = f;
      end
    end
    return best;
  endfunction

  task automatic model_update();
    bit [15:0] p;
    int cf, s;
    cf = int'(current_floor);
    if (rst) begin
      m_state = 0; m_pend = '0; m_tgt = 0; m_tv = 0; m_door = 0; m_up = 1; m_cnt = 0;
      return;
    end
    p = m_pend;
    if (call_valid && int'(call_floor) < NF && !(m_state == 2 && int'(call_floor) == cf))
      p[call_floor] = 1'b1;
    case (m_state)
      0: begin
        m_tgt = cf;
        if (m_pend[cf]) begin
          p[cf] = 1'b0; m_door = 1; m_cnt = 0; m_state = 2;
        end else if (m_pend != 0) begin
          s = m_sel(m_up, cf, m_pend);
          if (s < 0) begin
            m_up = ~m_up;
            s = m_sel(m_up, cf, m_pend);
          end
          m_tgt = s; m_tv = 1; m_state = 1;
        end
      end
      1: begin
        s = m_sel(m_up, cf, m_pend);
        if (cf == m_tgt && car_idle) begin
          p[cf] = 1'b0; m_tv = 0; m_door = 1; m_cnt = 0; m_state = 2;
        end else if (s >= 0 && (m_up ? s < m_tgt : s > m_tgt)) begin
          m_tgt = s;
        end
      end
      default: begin
        m_tgt = cf;
        if (m_cnt == DW - 1) begin
          m_door = 0; m_state = 0;
        end else begin
          m_cnt++;
        end
      end
    endcase
    m_pend = p;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] f);
    call_valid = 1'b1;
    call_floor = f;
    step();
    call_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; call_valid = 1'b1; call_floor = 4'd3; current_floor = 4'd0; car_idle = 1'b1;
    step(); step();
    call_valid = 1'b0; rst = 1'b0;
    n_checks++; if (target_floor !== 4'd0) $display("FAIL reset_target got=%0d exp=0", target_floor); else n_pass++;
    n_checks++; if (target_valid !== 1'b0) $display("FAIL reset_tvalid got=%b exp=0", target_valid); else n_pass++;
    n_checks++; if (door_open !== 1'b0) $display("FAIL reset_door got=%b exp=0", door_open); else n_pass++;
    n_checks++; if (dir_up !== 1'b1) $display("FAIL reset_dir got=%b exp=1", dir_up); else n_pass++;
    n_checks++; if (pending !== 10'h000) $display("FAIL reset_pending got=%h exp=000", pending); else n_pass++;
  endtask

  task automatic test_single_call();
    int n_door;
    press(4'd3);
    n_checks++; if (pending !== 10'h008) $display("FAIL t1_pending got=%h exp=008", pending); else n_pass++;
    n_checks++; if (target_valid !== 1'b0) $display("FAIL t1_tvalid_early got=%b exp=0", target_valid); else n_pass++;
    step();
    n_checks++; if (target_floor !== 4'd3) $display("FAIL t1_target got=%0d exp=3", target_floor); else n_pass++;
    n_checks++; if (target_valid !== 1'b1) $display("FAIL t1_tvalid got=%b exp=1", target_valid); else n_pass++;
    n_checks++; if (dir_up !== 1'b1) $display("FAIL t1_dir got=%b exp=1", dir_up); else n_pass++;
    current_floor = 4'd3; car_idle = 1'b1;
    step();
    n_checks++; if (pending !== 10'h000) $display("FAIL t1_cleared got=%h exp=000", pending); else n_pass++;
    n_checks++; if (target_valid !== 1'b0) $display("FAIL t1_tvalid_arrive got=%b exp=0", target_valid); else n_pass++;
    n_door = 0;
    for (int k = 0; k < 8; k++) begin
      if (door_open) n_door++;
      step();
    end
    n_checks++; if (n_door !== DW) $display("FAIL t1_dwell got=%0d exp=%0d", n_door, DW); else n_pass++;
    n_checks++; if (target_floor !== 4'd3) $display("FAIL t1_idle_target got=%0d exp=3", target_floor); else n_pass++;
  endtask

  task automatic test_retarget();
    current_floor = 4'd0; car_idle = 1'b1;
    do_reset();
    press(4'd7);
    step();
    n_checks++; if (target_floor !== 4'd7) $display("FAIL t2_target7 got=%0d exp=7", target_floor); else n_pass++;
    car_idle = 1'b0; current_floor = 4'd1; step();
    current_floor = 4'd2; step();
    press(4'd4);
    step();
    n_checks++; if (target_floor !== 4'd4) $display("FAIL t2_retarget got=%0d exp=4", target_floor); else n_pass++;
    current_floor = 4'd3; step();
    current_floor = 4'd4; car_idle = 1'b1; step();
    n_checks++; if (door_open !== 1'b1) $display("FAIL t2_door got=%b exp=1", door_open); else n_pass++;
    n_checks++; if (pending !== 10'h080) $display("FAIL t2_pending got=%h exp=080", pending); else n_pass++;
    repeat (5) step();
    n_checks++; if (target_floor !== 4'd7) $display("FAIL t2_resume got=%0d exp=7", target_floor); else n_pass++;
    n_checks++; if (target_valid !== 1'b1) $display("FAIL t2_resume_tv got=%b exp=1", target_valid); else n_pass++;
    current_floor = 4'd7; step();
    repeat (5) step();
    n_checks++; if (pending !== 10'h000) $display("FAIL t2_final got=%h exp=000", pending); else n_pass++;
  endtask

  task automatic test_look_reverse();
    current_floor = 4'd0; car_idle = 1'b1;
    do_reset();
    press(4'd5);
    step();
    current_floor = 4'd5; step();
    press(4'd2);
    press(4'd8);
    n_checks++; if (pending !== 10'h104) $display("FAIL t3_pending got=%h exp=104", pending); else n_pass++;
    repeat (3) step();
    n_checks++; if (target_floor !== 4'd8) $display("FAIL t3_up_first got=%0d exp=8", target_floor); else n_pass++;
    n_checks++; if (dir_up !== 1'b1) $display("FAIL t3_dir_up got=%b exp=1", dir_up); else n_pass++;
    current_floor = 4'd8; step();
    n_checks++; if (pending !== 10'h004) $display("FAIL t3_after8 got=%h exp=004", pending); else n_pass++;
    repeat (5) step();
    n_checks++; if (target_floor !== 4'd2) $display("FAIL t3_reverse got=%0d exp=2", target_floor); else n_pass++;
    n_checks++; if (dir_up !== 1'b0) $display("FAIL t3_dir_down got=%b exp=0", dir_up); else n_pass++;
    current_floor = 4'd2; step();
    repeat (5) step();
    n_checks++; if (pending !== 10'h000) $display("FAIL t3_final got=%h exp=000", pending); else n_pass++;
  endtask

  task automatic test_ignored_calls();
    int n_door;
    bit tv_seen, pend_nz;
    current_floor = 4'd5; step();
    press(4'd12);
    n_checks++; if (pending !== 10'h000) $display("FAIL t4_call12 got=%h exp=000", pending); else n_pass++;
    press(4'd5);
    n_checks++; if (pending !== 10'h020) $display("FAIL t5_pending got=%h exp=020", pending); else n_pass++;
    n_door = 0; tv_seen = 0; pend_nz = 0;
    for (int k = 0; k < 10; k++) begin
      call_valid = (k <= 3);
      call_floor = (k == 2) ? 4'd12 : 4'd5;
      step();
      call_valid = 1'b0;
      if (door_open) n_door++;
      if (target_valid) tv_seen = 1;
      if (pending != 0) pend_nz = 1;
    end
    n_checks++; if (n_door !== DW) $display("FAIL t4_dwell got=%0d exp=%0d", n_door, DW); else n_pass++;
    n_checks++; if (tv_seen !== 1'b0) $display("FAIL t5_tvalid got=%b exp=0", tv_seen); else n_pass++;
    n_checks++; if (pend_nz !== 1'b0) $display("FAIL t4_pending_nz got=%b exp=0", pend_nz); else n_pass++;
    n_checks++; if (target_floor !== 4'd5) $display("FAIL t5_target got=%0d exp=5", target_floor); else n_pass++;
  endtask

  task automatic test_reset_mid_move();
    press(4'd3);
    press(4'd6);
    n_checks++; if (target_valid !== 1'b1) $display("FAIL t6_moving got=%b exp=1", target_valid); else n_pass++;
    n_checks++; if (pending !== 10'h048) $display("FAIL t6_pending got=%h exp=048", pending); else n_pass++;
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++; if (target_floor !== 4'd0) $display("FAIL t6_target got=%0d exp=0", target_floor); else n_pass++;
    n_checks++; if (target_valid !== 1'b0) $display("FAIL t6_tvalid got=%b exp=0", target_valid); else n_pass++;
    n_checks++; if (dir_up !== 1'b1) $display("FAIL t6_dir got=%b exp=1", dir_up); else n_pass++;
    n_checks++; if (pending !== 10'h000) $display("FAIL t6_cleared got=%h exp=000", pending); else n_pass++;
    step();
    n_checks++; if (target_valid !== 1'b0 || door_open !== 1'b0) $display("FAIL t6_quiet got=%b%b exp=00", target_valid, door_open); else n_pass++;
  endtask

  task automatic test_random();
    logic [6+NF:0] act, exp;
    int mv_tmr, n_err;
    current_floor = 4'd0; car_idle = 1'b1;
    do_reset();
    mv_tmr = 0; n_err = 0;
    for (int cyc = 0; cyc < 4000 && n_err < 10; cyc++) begin
      rst = ($urandom_range(0, 599) == 0);
      call_valid = ($urandom_range(0, 3) == 0);
      call_floor = 4'($urandom_range(0, 15));
      step();
      act = {target_floor, target_valid, door_open, dir_up, pending};
      exp = {4'(m_tgt), m_tv, m_door, m_up, m_pend[NF-1:0]};
      n_checks++;
      if (act !== exp) begin
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act, exp);
        n_err++;
      end else begin
        n_pass++;
      end
      if (mv_tmr > 0) begin
        mv_tmr--;
      end else if (current_floor != target_floor) begin
        current_floor = (current_floor < target_floor) ? current_floor + 4'd1 : current_floor - 4'd1;
        mv_tmr = 1;
      end
      car_idle = (current_floor == target_floor) && ($urandom_range(0, 3) != 0);
    end
    rst = 1'b0; call_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    m_state = 0; m_pend = '0; m_tgt = 0; m_tv = 0; m_door = 0; m_up = 1; m_cnt = 0;
    rst = 1'b1; call_valid = 1'b0; call_floor = 4'd0; current_floor = 4'd0; car_idle = 1'b1;
    test_reset();
    test_single_call();
    test_retarget();
    test_look_reverse();
    test_ignored_calls();
    test_reset_mid_move();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
